// File: rtl/csr_access_unit.sv
// Zicsr requester-side sequencer: decodes one CSR instruction, reads/writes the CSR file over
// a handshaked port and returns the old value. Optional read-only check: define CSR_RO_CHECK_EN.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline request
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_funct3,
  input  logic [CSR_AW-1:0] i_csr_addr,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [4:0]        i_zimm,
  input  logic              i_rd_zero,
  // pipeline response
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [XLEN-1:0]   o_rd_data,
  output logic              o_illegal,
  // CSR file port
  output logic              o_csr_rd_en,
  output logic [CSR_AW-1:0] o_csr_addr,
  input  logic [XLEN-1:0]   i_csr_rdata,
  input  logic              i_csr_rvalid,
  output logic              o_csr_wr_en,
  output logic [XLEN-1:0]   o_csr_wdata,
  input  logic              i_csr_wack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_e;

  // funct3[1:0] selects the operation class; funct3[2] only selects the operand source.
  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } op_e;

  state_e            state_q;
  op_e               op_q;
  logic [XLEN-1:0]   operand_q;
  logic              wr_skip_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              illegal_q;
  logic [XLEN-1:0]   rd_data_q;
  logic              csr_rd_en_q;
  logic              csr_wr_en_q;
  logic [CSR_AW-1:0] csr_addr_q;
  logic [XLEN-1:0]   csr_wdata_q;

  op_e             op_in;
  logic [XLEN-1:0] operand_in;
  logic            wr_skip_in;
  logic            rd_skip_in;
  logic            ro_fault_in;
  logic            illegal_in;

  function automatic logic [XLEN-1:0] new_value(input op_e op, input logic [XLEN-1:0] old_v,
                                                input logic [XLEN-1:0] operand);
    logic [XLEN-1:0] res;
    case (op)
      OP_RW:   res = operand;
      OP_RS:   res = old_v | operand;
      OP_RC:   res = old_v & ~operand;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign op_in      = op_e'(i_funct3[1:0]);
  assign operand_in = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_zimm} : i_rs1_data;
  // Set/clear with a zero rs1 field is a pure read; RW with rd=x0 is a pure write.
  assign wr_skip_in = ((op_in == OP_RS) || (op_in == OP_RC)) && (i_zimm == 5'd0);
  assign rd_skip_in = (op_in == OP_RW) && i_rd_zero;

`ifdef CSR_RO_CHECK_EN
  assign ro_fault_in = (i_csr_addr[CSR_AW-1 -: 2] == 2'b11) && !wr_skip_in;
`else
  assign ro_fault_in = 1'b0;
`endif

  assign illegal_in = (op_in == OP_ILL) || ro_fault_in;

  // NOTE: all state below is sequential and uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ILL;
      operand_q    <= '0;
      wr_skip_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      rd_data_q    <= '0;
      csr_rd_en_q  <= 1'b0;
      csr_wr_en_q  <= 1'b0;
      csr_addr_q   <= '0;
      csr_wdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (i_req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= op_in;
            operand_q   <= operand_in;
            wr_skip_q   <= wr_skip_in;
            csr_addr_q  <= i_csr_addr;
            rd_data_q   <= '0;
            illegal_q   <= 1'b0;
            if (illegal_in) begin
              illegal_q    <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (rd_skip_in) begin
              // Skipped read means the old value is taken as zero.
              csr_wr_en_q <= 1'b1;
              csr_wdata_q <= new_value(op_in, '0, operand_in);
              state_q     <= S_WR;
            end else begin
              csr_rd_en_q <= 1'b1;
              state_q     <= S_RD;
            end
          end
        end

        S_RD: begin
          if (i_csr_rvalid) begin
            csr_rd_en_q <= 1'b0;
            rd_data_q   <= i_csr_rdata;
            if (wr_skip_q) begin
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              csr_wr_en_q <= 1'b1;
              csr_wdata_q <= new_value(op_q, i_csr_rdata, operand_q);
              state_q     <= S_WR;
            end
          end
        end

        S_WR: begin
          if (i_csr_wack) begin
            csr_wr_en_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end

        S_RESP: begin
          if (i_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_illegal    = illegal_q;
  assign o_csr_rd_en  = csr_rd_en_q;
  assign o_csr_wr_en  = csr_wr_en_q;
  assign o_csr_addr   = csr_addr_q;
  assign o_csr_wdata  = csr_wdata_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit; the read-only-space step adapts to CSR_RO_CHECK_EN.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_funct3;
  logic [11:0] i_csr_addr;
  logic [31:0] i_rs1_data;
  logic [4:0]  i_zimm;
  logic        i_rd_zero;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_rd_data;
  logic        o_illegal;
  logic        o_csr_rd_en;
  logic [11:0] o_csr_addr;
  logic [31:0] i_csr_rdata;
  logic        i_csr_rvalid;
  logic        o_csr_wr_en;
  logic [31:0] o_csr_wdata;
  logic        i_csr_wack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(32), .CSR_AW(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_funct3     (i_funct3),
    .i_csr_addr   (i_csr_addr),
    .i_rs1_data   (i_rs1_data),
    .i_zimm       (i_zimm),
    .i_rd_zero    (i_rd_zero),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_rd_data    (o_rd_data),
    .o_illegal    (o_illegal),
    .o_csr_rd_en  (o_csr_rd_en),
    .o_csr_addr   (o_csr_addr),
    .i_csr_rdata  (i_csr_rdata),
    .i_csr_rvalid (i_csr_rvalid),
    .o_csr_wr_en  (o_csr_wr_en),
    .o_csr_wdata  (o_csr_wdata),
    .i_csr_wack   (i_csr_wack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                       input logic [4:0] zimm, input logic rd_zero);
    i_funct3    = f3;
    i_csr_addr  = addr;
    i_rs1_data  = rs1;
    i_zimm      = zimm;
    i_rd_zero   = rd_zero;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_funct3 = '0; i_csr_addr = '0; i_rs1_data = '0; i_zimm = '0;
    i_rd_zero = 1'b0; i_resp_ready = 1'b0; i_csr_rdata = '0; i_csr_rvalid = 1'b0;
    i_csr_wack = 1'b0;
    tick(); tick();

    check("rst_ready",      {31'b0, o_req_ready},  32'd0);
    check("rst_rd_en",      {31'b0, o_csr_rd_en},  32'd0);
    check("rst_wr_en",      {31'b0, o_csr_wr_en},  32'd0);
    check("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
    check("rst_illegal",    {31'b0, o_illegal},    32'd0);
    check("rst_rd_data",    o_rd_data,             32'd0);
    check("rst_wdata",      o_csr_wdata,           32'd0);
    check("rst_addr",       {20'b0, o_csr_addr},   32'd0);
    rst = 1'b0;
    check("release_ready_low", {31'b0, o_req_ready}, 32'd0);
    tick();
    check("release_ready_high", {31'b0, o_req_ready}, 32'd1);

    // CSRRW 0x340 <- 0xDEADBEEF, CSR holds 0x12345678, zero-wait CSR.
    issue(3'b001, 12'h340, 32'hDEADBEEF, 5'd7, 1'b0);
    check("rw_c1_rd_en", {31'b0, o_csr_rd_en}, 32'd1);
    check("rw_c1_wr_en", {31'b0, o_csr_wr_en}, 32'd0);
    check("rw_c1_ready", {31'b0, o_req_ready}, 32'd0);
    check("rw_c1_addr",  {20'b0, o_csr_addr},  32'h340);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'h12345678;
    tick();
    i_csr_rvalid = 1'b0;
    check("rw_c2_rd_en", {31'b0, o_csr_rd_en}, 32'd0);
    check("rw_c2_wr_en", {31'b0, o_csr_wr_en}, 32'd1);
    check("rw_c2_wdata", o_csr_wdata, 32'hDEADBEEF);
    i_csr_wack = 1'b1;
    tick();
    i_csr_wack = 1'b0;
    check("rw_c3_resp_valid", {31'b0, o_resp_valid}, 32'd1);
    check("rw_c3_rd_data",    o_rd_data,             32'h12345678);
    check("rw_c3_illegal",    {31'b0, o_illegal},    32'd0);
    check("rw_c3_wr_en",      {31'b0, o_csr_wr_en},  32'd0);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    check("rw_c4_resp_valid", {31'b0, o_resp_valid}, 32'd0);
    check("rw_c4_ready",      {31'b0, o_req_ready},  32'd1);

    // CSRRS with rs1 field 0: read only, CSR holds 0xA5.
    issue(3'b010, 12'h300, 32'h0, 5'd0, 1'b0);
    check("rs0_c1_rd_en", {31'b0, o_csr_rd_en}, 32'd1);
    check("rs0_c1_wr_en", {31'b0, o_csr_wr_en}, 32'd0);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'hA5;
    tick();
    i_csr_rvalid = 1'b0;
    check("rs0_c2_resp_valid", {31'b0, o_resp_valid}, 32'd1);
    check("rs0_c2_rd_data",    o_rd_data,             32'hA5);
    check("rs0_c2_wr_en",      {31'b0, o_csr_wr_en},  32'd0);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;

    // CSRRS register form: 0x00F0 | 0x0F00.
    issue(3'b010, 12'h305, 32'h0F00, 5'd2, 1'b0);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'h00F0;
    tick();
    i_csr_rvalid = 1'b0;
    check("rs_wdata", o_csr_wdata, 32'h0FF0);
    i_csr_wack = 1'b1;
    tick();
    i_csr_wack = 1'b0;
    check("rs_rd_data", o_rd_data, 32'h00F0);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;

    // CSRRCI zimm=3, CSR holds 0xFF, rvalid two cycles late, stray wack while reading.
    issue(3'b111, 12'h344, 32'hFFFF_FFFF, 5'd3, 1'b0);
    check("rci_c1_rd_en", {31'b0, o_csr_rd_en}, 32'd1);
    i_csr_wack = 1'b1;
    tick();
    i_csr_wack = 1'b0;
    check("rci_c2_rd_en", {31'b0, o_csr_rd_en}, 32'd1);
    check("rci_c2_wr_en", {31'b0, o_csr_wr_en}, 32'd0);
    tick();
    check("rci_c3_rd_en", {31'b0, o_csr_rd_en}, 32'd1);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'hFF;
    tick();
    i_csr_rvalid = 1'b0;
    check("rci_c4_wr_en", {31'b0, o_csr_wr_en}, 32'd1);
    check("rci_c4_rd_en", {31'b0, o_csr_rd_en}, 32'd0);
    check("rci_c4_wdata", o_csr_wdata,          32'hFC);
    i_csr_wack = 1'b1;
    tick();
    i_csr_wack = 1'b0;
    check("rci_c5_resp_valid", {31'b0, o_resp_valid}, 32'd1);
    check("rci_c5_rd_data",    o_rd_data,             32'hFF);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;

    // CSRRWI rd=x0, zimm=0x1F: write only, stray rvalid ignored, 3 cycles of backpressure.
    issue(3'b101, 12'h340, 32'h55, 5'h1F, 1'b1);
    check("rwi_c1_rd_en", {31'b0, o_csr_rd_en}, 32'd0);
    check("rwi_c1_wr_en", {31'b0, o_csr_wr_en}, 32'd1);
    check("rwi_c1_wdata", o_csr_wdata,          32'h1F);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'hBAD0_BAD0;
    tick();
    check("rwi_c2_wr_en_held", {31'b0, o_csr_wr_en}, 32'd1);
    i_csr_rvalid = 1'b0;
    i_csr_wack = 1'b1;
    tick();
    i_csr_wack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rwi_hold_resp_valid", {31'b0, o_resp_valid}, 32'd1);
      check("rwi_hold_rd_data",    o_rd_data,             32'd0);
      check("rwi_hold_ready",      {31'b0, o_req_ready},  32'd0);
      tick();
    end
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    check("rwi_done_ready", {31'b0, o_req_ready}, 32'd1);

    // Illegal funct3=100.
    issue(3'b100, 12'h340, 32'h1, 5'd1, 1'b0);
    check("ill_resp_valid", {31'b0, o_resp_valid}, 32'd1);
    check("ill_illegal",    {31'b0, o_illegal},    32'd1);
    check("ill_rd_data",    o_rd_data,             32'd0);
    check("ill_rd_en",      {31'b0, o_csr_rd_en},  32'd0);
    check("ill_wr_en",      {31'b0, o_csr_wr_en},  32'd0);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;

    // CSRRW to read-only space 0xC00.
    issue(3'b001, 12'hC00, 32'h7, 5'd1, 1'b0);
`ifdef CSR_RO_CHECK_EN
    check("ro_resp_valid", {31'b0, o_resp_valid}, 32'd1);
    check("ro_illegal",    {31'b0, o_illegal},    32'd1);
    check("ro_rd_data",    o_rd_data,             32'd0);
    check("ro_rd_en",      {31'b0, o_csr_rd_en},  32'd0);
    check("ro_wr_en",      {31'b0, o_csr_wr_en},  32'd0);
`else
    check("ro_rd_en", {31'b0, o_csr_rd_en}, 32'd1);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'h11;
    tick();
    i_csr_rvalid = 1'b0;
    check("ro_wr_en", {31'b0, o_csr_wr_en}, 32'd1);
    check("ro_wdata", o_csr_wdata,          32'h7);
    i_csr_wack = 1'b1;
    tick();
    i_csr_wack = 1'b0;
    check("ro_illegal", {31'b0, o_illegal}, 32'd0);
    check("ro_rd_data", o_rd_data,          32'h11);
`endif
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;

    // Reset while WR waits for wack, then a fresh CSRRS completes.
    issue(3'b101, 12'h341, 32'h0, 5'd4, 1'b1);
    tick();
    check("abort_wr_waiting", {31'b0, o_csr_wr_en}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_wr_dropped", {31'b0, o_csr_wr_en},  32'd0);
    check("abort_resp_valid", {31'b0, o_resp_valid}, 32'd0);
    tick();
    check("abort_ready", {31'b0, o_req_ready}, 32'd1);
    check("abort_wr_en", {31'b0, o_csr_wr_en}, 32'd0);
    issue(3'b010, 12'h342, 32'h1, 5'd1, 1'b0);
    check("post_rd_en", {31'b0, o_csr_rd_en}, 32'd1);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'h10;
    tick();
    i_csr_rvalid = 1'b0;
    check("post_wdata", o_csr_wdata, 32'h11);
    i_csr_wack = 1'b1;
    tick();
    i_csr_wack = 1'b0;
    check("post_resp_valid", {31'b0, o_resp_valid}, 32'd1);
    check("post_rd_data",    o_rd_data,             32'h10);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    check("post_ready", {31'b0, o_req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Requester-side sequencer for Zicsr instructions, sitting between the execute stage and the `csr` register file. It accepts one decoded CSR instruction at a time and computes the effective write value for RW, RS and RC and their immediate forms. It issues a read request and/or a write request to the CSR file over a handshaked port, then returns the old CSR value to the pipeline for `rd` writeback.

## Interface
- `XLEN`, 32: data width of CSR values and rs1 operand.
- `CSR_AW`, 12: CSR address width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  1  pipeline offers an instruction.
- `o_req_ready`  out  1  unit can accept; high only in IDLE.
- `i_funct3`  in  3  Zicsr funct3.
- `i_csr_addr`  in  CSR_AW  target CSR.
- `i_rs1_data`  in  XLEN  rs1 value for register forms.
- `i_zimm`  in  5  rs1 field; zero-extended for immediate forms.
- `i_rd_zero`  in  1  rd field is x0.
- `o_resp_valid`  out  1  result available.
- `i_resp_ready`  in  1  pipeline takes result.
- `o_rd_data`  out  XLEN  old CSR value.
- `o_illegal`  out  1  instruction is illegal; qualified by `o_resp_valid`.
- `o_csr_rd_en`  out  1  read request, held until `i_csr_rvalid`.
- `o_csr_addr`  out  CSR_AW  latched address, valid with either request.
- `i_csr_rdata`  in  XLEN  read data.
- `i_csr_rvalid`  in  1  read data valid.
- `o_csr_wr_en`  out  1  write request, held until `i_csr_wack`.
- `o_csr_wdata`  out  XLEN  new value.
- `i_csr_wack`  in  1  write accepted.

## Operation
- Accept occurs when `i_req_valid && o_req_ready`. On accept, latch funct3, addr, operand, `i_rd_zero`, and `wr_skip`.
- Operand selection: funct3[2]=1 uses `{27'b0,i_zimm}`; otherwise `i_rs1_data`.
- `wr_skip` is set for RS/RC/RSI/RCI when `i_zimm` (rs1 field) is 0. RW/RWI always write.
- `rd_skip` is set only for RW/RWI with `i_rd_zero`=1. All other forms always read.
- funct3 000 or 100 is illegal: no CSR access; go to RESP with `o_illegal`=1 and `o_rd_data`=0.
- Write value by form:
  - RW: operand.
  - RS: `old | operand`.
  - RC: `old & ~operand`.
  - `old`=0 when the read is skipped; only RW-class writes skip the read.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE→RD on accept when not `rd_skip`.
  - IDLE→WR when `rd_skip`.
  - IDLE→RESP when illegal.
  - RD: `o_csr_rd_en`=1. On `i_csr_rvalid`, latch `i_csr_rdata` into `o_rd_data`, then →WR, or →RESP if `wr_skip`.
  - WR: `o_csr_wr_en`=1 with stable `o_csr_wdata`. On `i_csr_wack`, →RESP.
  - RESP: `o_resp_valid`=1 with `o_rd_data`/`o_illegal` stable. On `i_resp_ready`, →IDLE.
- Never drive `o_csr_rd_en` and `o_csr_wr_en` in the same cycle.

## Timing
- Reset values:
  - state IDLE.
  - `o_req_ready`=0 while `rst`=1, 1 from the first cycle after release.
  - All other outputs 0.
- `rst` mid-operation aborts the instruction: requests drop at the next edge and the state returns to IDLE; the result is discarded.
- `i_csr_rvalid`/`i_csr_wack` are sampled only while the matching enable is high. They may arrive in the first cycle of the enable. Pulses seen in other states are ignored.
- Minimum latency, accept at cycle 0:
  - RD at cycle 1 → WR at 2 → `o_resp_valid` at 3.
  - With one phase skipped, `o_resp_valid` at 2.
  - Illegal: `o_resp_valid` at 1.
- Each wait cycle on rvalid/wack adds one cycle. Backpressure on `i_resp_ready` holds RESP indefinitely.
- `o_req_ready` is low from the cycle after accept until the cycle after the response is taken. There is no back-to-back overlap.

## Configuration
- `CSR_RO_CHECK_EN` defined: addr[11:10]==2'b11 (read-only space) combined with a non-skipped write is illegal. No read or write is issued; the unit responds with `o_illegal`=1 and `o_rd_data`=0, 1 cycle after accept. Reads of read-only CSRs with `wr_skip` proceed normally.
- Undefined: no address check; such writes are forwarded to the CSR file, which ignores or handles them.

## Test plan
- CSRRW addr 0x340, rs1=0xDEADBEEF, rd≠x0, CSR holds 0x12345678, zero-wait CSR → read then write 0xDEADBEEF; `o_rd_data`=0x12345678 at cycle 3.
- CSRRS rs1 field 0, CSR holds 0xA5 → read only, `o_csr_wr_en` never high, `o_rd_data`=0xA5 at cycle 2.
- CSRRCI zimm=0x3, CSR holds 0xFF, rvalid delayed 2 cycles → write 0xFC, response at cycle 5.
- CSRRWI rd=x0, zimm=0x1F → no read, write 0x1F; `o_rd_data`=0; `i_resp_ready` low 3 cycles → outputs held stable.
- funct3=100, then CSRRW to 0xC00 with `CSR_RO_CHECK_EN` → both give `o_illegal`=1 at cycle 1, no CSR requests. Without the macro, the write to 0xC00 is issued.
- `rst` pulsed while WR waits for wack → `o_csr_wr_en`=0 and `o_req_ready`=1 after release; a new request completes normally.
